// File: rtl/numbers.sv
// numbers: hex-value overlay for the VGA pixel pipeline.
// Draws var1..var3 as three rows of four 7-segment-style hex digits in
// 8x8 cells. The input values are captured into shadow registers at raster
// coordinate (0,0), so the display does not tear mid-frame. The output
// pixel flag is registered and has a latency of one clock.
// Optional feature: define NUMBERS_BOX_EN to add a 1-px outline around the
// whole text block.
module numbers #(
  parameter int unsigned X0        = 16,
  parameter int unsigned Y0        = 16,
  parameter int unsigned ROW_PITCH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x_px,
  input  logic [9:0]  y_px,
  input  logic [15:0] var1,
  input  logic [15:0] var2,
  input  logic [15:0] var3,
  output logic        pixel
);

  localparam logic [9:0] X0_L   = 10'(X0);
  localparam logic [9:0] ROW0_L = 10'(Y0);
  localparam logic [9:0] ROW1_L = 10'(Y0 + ROW_PITCH);
  localparam logic [9:0] ROW2_L = 10'(Y0 + 2 * ROW_PITCH);

`ifdef NUMBERS_BOX_EN
  localparam logic [9:0] BOX_L_L = 10'(X0 - 2);
  localparam logic [9:0] BOX_R_L = 10'(X0 + 33);
  localparam logic [9:0] BOX_T_L = 10'(Y0 - 2);
  localparam logic [9:0] BOX_B_L = 10'(Y0 + 2 * ROW_PITCH + 9);
`endif

  // Segment mask for a hex nibble, packed as {a,b,c,d,e,f,g}.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b0011111;
      4'hC:    seg = 7'b1001110;
      4'hD:    seg = 7'b0111101;
      4'hE:    seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
    return seg;
  endfunction

  // True when cell position (cx,cy) belongs to a segment that is enabled.
  // Column 7 and row 7 never match any segment, which leaves the spacing dark.
  function automatic logic seg_on(input logic [2:0] cx, input logic [2:0] cy,
                                  input logic [6:0] seg);
    logic mid_x;
    logic upper_y;
    logic lower_y;
    mid_x   = (cx >= 3'd1) && (cx <= 3'd5);
    upper_y = (cy == 3'd1) || (cy == 3'd2);
    lower_y = (cy == 3'd4) || (cy == 3'd5);
    return (seg[6] && cy == 3'd0 && mid_x)     // a
         | (seg[5] && cx == 3'd6 && upper_y)   // b
         | (seg[4] && cx == 3'd6 && lower_y)   // c
         | (seg[3] && cy == 3'd6 && mid_x)     // d
         | (seg[2] && cx == 3'd0 && lower_y)   // e
         | (seg[1] && cx == 3'd0 && upper_y)   // f
         | (seg[0] && cy == 3'd3 && mid_x);    // g
  endfunction

  logic [15:0] var1_q, var2_q, var3_q;
  logic        pixel_q, pixel_d;

  logic [9:0]  dx, dy0, dy1, dy2;
  logic        col_hit;
  logic        row_hit;
  logic [2:0]  cy;
  logic [15:0] row_val;
  logic [3:0]  nib;
  logic        glyph_lit;
  logic        box_lit;

  // Offsets from the text origin; wrap-around below the origin is masked by
  // the >= tests, so plain unsigned 10-bit arithmetic is enough.
  assign dx      = x_px - X0_L;
  assign dy0     = y_px - ROW0_L;
  assign dy1     = y_px - ROW1_L;
  assign dy2     = y_px - ROW2_L;
  assign col_hit = (x_px >= X0_L) && (dx < 10'd32);

  // Select the text row under the beam and its shadowed value.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    row_hit = 1'b0;
    cy      = 3'd0;
    row_val = 16'h0000;
    if ((y_px >= ROW0_L) && (dy0 < 10'd8)) begin
      row_hit = 1'b1;
      cy      = dy0[2:0];
      row_val = var1_q;
    end else if ((y_px >= ROW1_L) && (dy1 < 10'd8)) begin
      row_hit = 1'b1;
      cy      = dy1[2:0];
      row_val = var2_q;
    end else if ((y_px >= ROW2_L) && (dy2 < 10'd8)) begin
      row_hit = 1'b1;
      cy      = dy2[2:0];
      row_val = var3_q;
    end
  end

  // Pick the nibble for the digit under the beam; digit 0 is the MS nibble.
  always_comb begin
    nib = 4'h0;
    case (dx[4:3])
      2'd0:    nib = row_val[15:12];
      2'd1:    nib = row_val[11:8];
      2'd2:    nib = row_val[7:4];
      default: nib = row_val[3:0];
    endcase
  end

  assign glyph_lit = row_hit && col_hit && seg_on(dx[2:0], cy, glyph(nib));

`ifdef NUMBERS_BOX_EN
  assign box_lit = (((x_px == BOX_L_L) || (x_px == BOX_R_L)) &&
                    (y_px >= BOX_T_L) && (y_px <= BOX_B_L)) ||
                   (((y_px == BOX_T_L) || (y_px == BOX_B_L)) &&
                    (x_px >= BOX_L_L) && (x_px <= BOX_R_L));
`else
  assign box_lit = 1'b0;
`endif

  assign pixel_d = glyph_lit || box_lit;
  assign pixel   = pixel_q;

  // Frame-start value capture and the one-clock registered pixel output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      var1_q  <= 16'h0000;
      var2_q  <= 16'h0000;
      var3_q  <= 16'h0000;
      pixel_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so the order of these statements does not matter.
      pixel_q <= pixel_d;
      if ((x_px == 10'd0) && (y_px == 10'd0)) begin
        var1_q <= var1;
        var2_q <= var2;
        var3_q <= var3;
      end
    end
  end

endmodule

// File: tb/tb_numbers.sv
// Testbench for numbers: directed points from the overlay geometry plus a
// full raster scan and random coordinates, all checked against a reference
// model that renders glyphs from segment-letter strings.
module tb_numbers;

  localparam int X0        = 16;
  localparam int Y0        = 16;
  localparam int ROW_PITCH = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x_px, y_px;
  logic [15:0] var1, var2, var3;
  logic        pixel;

  int checks = 0;
  int errors = 0;

  // Shadow values as the reference model believes them to be.
  logic [15:0] m_sh1, m_sh2, m_sh3;

  numbers #(.X0(X0), .Y0(Y0), .ROW_PITCH(ROW_PITCH)) dut (
    .clk   (clk),
    .reset (reset),
    .x_px  (x_px),
    .y_px  (y_px),
    .var1  (var1),
    .var2  (var2),
    .var3  (var3),
    .pixel (pixel)
  );

  always #5 clk = ~clk;

  // Segment letters lit for each hex digit.
  string glyphs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                         "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                         "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  // Which segment letter (if any) covers cell position (cx,cy); 0 = none.
  function automatic byte seg_at(input int cx, input int cy);
    if (cx == 7 || cy == 7) return 8'd0;
    if (cx >= 1 && cx <= 5) begin
      if (cy == 0) return "a";
      if (cy == 3) return "g";
      if (cy == 6) return "d";
    end
    if (cx == 0 && (cy == 1 || cy == 2)) return "f";
    if (cx == 6 && (cy == 1 || cy == 2)) return "b";
    if (cx == 0 && (cy == 4 || cy == 5)) return "e";
    if (cx == 6 && (cy == 4 || cy == 5)) return "c";
    return 8'd0;
  endfunction

  function automatic bit model_lit(input int x, input int y);
    logic [15:0] vals [3];
    vals[0] = m_sh1;
    vals[1] = m_sh2;
    vals[2] = m_sh3;
`ifdef NUMBERS_BOX_EN
    if ((x == X0 - 2 || x == X0 + 33) && y >= Y0 - 2 && y <= Y0 + 2 * ROW_PITCH + 9)
      return 1'b1;
    if ((y == Y0 - 2 || y == Y0 + 2 * ROW_PITCH + 9) && x >= X0 - 2 && x <= X0 + 33)
      return 1'b1;
`endif
    for (int r = 0; r < 3; r++) begin
      int top;
      top = Y0 + r * ROW_PITCH;
      if (y >= top && y <= top + 7) begin
        for (int d = 0; d < 4; d++) begin
          int left;
          left = X0 + 8 * d;
          if (x >= left && x <= left + 7) begin
            int  nib;
            byte s;
            string g;
            nib = (int'(vals[r]) >> (12 - 4 * d)) & 15;
            s   = seg_at(x - left, y - top);
            g   = glyphs[nib];
            if (s == 8'd0) return 1'b0;
            for (int i = 0; i < g.len(); i++)
              if (g[i] == s) return 1'b1;
            return 1'b0;
          end
        end
      end
    end
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: pixel=%0b expected %0b", tag, observed, expected);
    end
  endtask

  // Present (x,y) for one clock and check the registered result afterwards.
  // Called at posedge+1, returns at posedge+1.
  task automatic step(input int x, input int y, input string tag);
    logic exp;
    x_px = 10'(x);
    y_px = 10'(y);
    exp  = model_lit(x, y);
    if (x == 0 && y == 0) begin
      m_sh1 = var1;
      m_sh2 = var2;
      m_sh3 = var3;
    end
    @(posedge clk);
    #1;
    check(tag, pixel, exp);
  endtask

  // Directed point with a hand-derived expectation.
  task automatic point(input int x, input int y, input logic exp, input string tag);
    x_px = 10'(x);
    y_px = 10'(y);
    @(posedge clk);
    #1;
    check(tag, pixel, exp);
  endtask

  initial begin
    reset = 1'b0;
    x_px  = 10'd22;
    y_px  = 10'd17;
    var1  = 16'h1111;
    var2  = 16'hAAAA;
    var3  = 16'h1010;
    m_sh1 = 16'h0000;
    m_sh2 = 16'h0000;
    m_sh3 = 16'h0000;

    // Held in reset: output stays low even on a lit coordinate.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", pixel, 1'b0);
    end
    reset = 1'b1;

    // Full raster scan starting at (0,0), which latches the values.
    for (int y = 0; y <= 100; y++)
      for (int x = 0; x <= 201; x++)
        step(x, y, "scan");

    // Digit '1' on row 0.
    point(22, 17, 1'b1, "one_seg_b");
    point(16, 16, 1'b0, "one_corner");
    point(17, 16, 1'b0, "one_no_a");
    // Digit 'A' on row 1.
    for (int x = 17; x <= 21; x++) point(x, 26, 1'b1, "A_seg_a");
    point(17, 32, 1'b0, "A_no_d");
    // Row 2 digit 1 is '0'.
    point(24, 37, 1'b1, "zero_seg_f");
    point(25, 39, 1'b0, "zero_no_g");
    point(25, 42, 1'b1, "zero_seg_d");
    // Outside the text area.
    point(50, 20, 1'b0, "out_right");
    point(20, 24, 1'b0, "out_gap24");
    point(20, 25, 1'b0, "out_gap25");
    point(200, 100, 1'b0, "out_far");
    point(1023, 1023, 1'b0, "out_max");
`ifdef NUMBERS_BOX_EN
    point(14, 14, 1'b1, "box_tl");
    point(49, 45, 1'b1, "box_br");
`else
    point(14, 14, 1'b0, "nobox_tl");
    point(49, 45, 1'b0, "nobox_br");
`endif

    // Mid-frame change has no effect until the next (0,0).
    var1 = 16'h8888;
    point(17, 19, 1'b0, "no_tear");
    point(0, 0, 1'b0, "latch_origin");
    m_sh1 = 16'h8888;
    point(17, 19, 1'b1, "eight_seg_g");

    // Random values and coordinates, with unlatched value changes mixed in.
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        var1 = 16'($urandom);
        var2 = 16'($urandom);
        var3 = 16'($urandom);
        step(0, 0, "rand_latch");
      end else if (n % 37 == 0) begin
        var1 = 16'($urandom);
        var2 = 16'($urandom);
        var3 = 16'($urandom);
      end
      if ($urandom_range(7, 0) == 0)
        step(int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)), "rand_far");
      else
        step(int'($urandom_range(60, 0)), int'($urandom_range(50, 0)), "rand_area");
    end

    // Asynchronous reset mid-frame clears output and shadows at once.
    var1 = 16'h1111;
    step(0, 0, "pre_reset_latch");
    step(22, 17, "pre_reset_lit");
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_pixel", pixel, 1'b0);
    m_sh1 = 16'h0000;
    m_sh2 = 16'h0000;
    m_sh3 = 16'h0000;
    @(posedge clk);
    #1;
    reset = 1'b1;
    // Shadow is 0x0000, so digit '0' shows segment a at (17,16).
    step(17, 16, "reset_shadow_zero");
    point(17, 16, 1'b1, "reset_shadow_zero_a");
    point(17, 19, 1'b0, "reset_shadow_zero_g");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
